// File: rtl/prgmux_seq.sv
// prgmux_seq: round-robin arbiter slicing CH address requesters onto a shared JW-bit bus (PRGMUX_PARITY_EN adds jpar/jerr replay/perr)
module prgmux_seq #(
  parameter int CH = 3,
  parameter int AW = 19,
  parameter int JW = 16,
  parameter int SETUP = 1,
  localparam int BEATS = (AW + JW - 1) / JW,
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1,
  localparam int CW = CH > 1 ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [CH-1:0]    req,
  input  logic [CH*AW-1:0] addr,
  output logic [CH-1:0]    ack,
  output logic [JW-1:0]    j,
  output logic [BW-1:0]    js,
  output logic [CW-1:0]    jch,
  output logic             jstb,
  output logic             busy
`ifdef PRGMUX_PARITY_EN
  ,
  output logic             jpar,
  input  logic             jerr,
  output logic             perr
`endif
);
  localparam int SW = BEATS * JW;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_DONE} state_t;
  localparam state_t S_FIRST = SETUP == 0 ? S_STROBE : S_SETUP;
  state_t st, st_n;
  logic [SW-1:0] sr, sr_n;
  logic [AW-1:0] a_sel;
  logic [CW-1:0] ptr, ptr_n, cur, cur_n, gnt;
  logic [BW-1:0] beat, beat_n;
  logic [3:0] cnt, cnt_n;
  logic found, grant, last, act, replay;
  // first pass covers channels at or above the pointer, second pass wraps around
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int c = 0; c < CH; c++)
      if (!found && req[c] && CW'(c) >= ptr) begin
        found = 1'b1;
        gnt = CW'(c);
      end
    for (int c = 0; c < CH; c++)
      if (!found && req[c]) begin
        found = 1'b1;
        gnt = CW'(c);
      end
    a_sel = '0;
    for (int c = 0; c < CH; c++)
      if (gnt == CW'(c)) a_sel = addr[c*AW +: AW];
  end
  assign grant = st == S_IDLE && found;
  assign last = beat == BW'(BEATS - 1);
  always_comb begin
    st_n = st;
    sr_n = sr;
    ptr_n = ptr;
    cur_n = cur;
    beat_n = beat;
    cnt_n = cnt;
    case (st)
      S_IDLE:
        if (found) begin
          st_n = S_FIRST;
          sr_n = SW'(a_sel);
          cur_n = gnt;
          beat_n = '0;
          cnt_n = '0;
        end
      S_SETUP: begin
        cnt_n = cnt + 4'd1;
        if (cnt == 4'(SETUP - 1)) st_n = S_STROBE;
      end
      S_STROBE:
        if (replay) begin
          st_n = S_FIRST;
          cnt_n = '0;
        end else if (last) st_n = S_DONE;
        else begin
          st_n = S_FIRST;
          cnt_n = '0;
          beat_n = beat + BW'(1);
          sr_n = sr >> JW;
        end
      default: begin
        st_n = S_IDLE;
        ptr_n = cur == CW'(CH - 1) ? '0 : cur + CW'(1);
      end
    endcase
  end
  assign act = st_n == S_SETUP || st_n == S_STROBE;
  // outputs are registered from next-state values so they line up with the state they describe
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      st <= S_IDLE;
      sr <= '0;
      ptr <= '0;
      cur <= '0;
      beat <= '0;
      cnt <= '0;
      j <= '0;
      js <= '0;
      jch <= '0;
      jstb <= 1'b0;
      ack <= '0;
      busy <= 1'b0;
    end else begin
      st <= st_n;
      sr <= sr_n;
      ptr <= ptr_n;
      cur <= cur_n;
      beat <= beat_n;
      cnt <= cnt_n;
      j <= act ? sr_n[JW-1:0] : '0;
      js <= act ? beat_n : '0;
      jch <= st_n != S_IDLE ? cur_n : '0;
      jstb <= st_n == S_STROBE;
      ack <= st_n == S_DONE ? CH'(1) << cur_n : '0;
      busy <= st_n != S_IDLE;
    end
`ifdef PRGMUX_PARITY_EN
  logic [1:0] rty;
  logic err, err_nx;
  assign replay = st == S_STROBE && jerr && rty != 2'd3;
  assign err_nx = err | (st == S_STROBE && jerr && !replay);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rty <= '0;
      err <= 1'b0;
      jpar <= 1'b0;
      perr <= 1'b0;
    end else begin
      rty <= grant || (st == S_STROBE && !replay) ? '0 : replay ? rty + 2'd1 : rty;
      err <= grant ? 1'b0 : err_nx;
      jpar <= act ? ^sr_n[JW-1:0] : 1'b0;
      perr <= grant ? 1'b0 : st_n == S_DONE ? err_nx : perr;
    end
`else
  assign replay = 1'b0;
`endif
endmodule

// File: tb/tb_prgmux_seq.sv
// tb_prgmux_seq: randomized bench for prgmux_seq against a transaction-level reference model
module tb_prgmux_seq;
  localparam int CH = 3, AW = 19, JW = 16, SETUP = 1, CW = 2;
  localparam int BEATS = (AW + JW - 1) / JW, SW = BEATS * JW;
  typedef struct packed {
    logic [JW-1:0] j;
    logic [0:0] js;
    logic [CW-1:0] jch;
    logic stb;
    logic [CH-1:0] ack;
    logic busy;
    logic dv;
  } rec_t;
  logic clk = 1'b0, resetn = 1'b0;
  logic [CH-1:0] req = '0, ack;
  logic [AW-1:0] ad [CH];
  logic [CH*AW-1:0] addr;
  logic [JW-1:0] j;
  logic [0:0] js;
  logic [CW-1:0] jch;
  logic jstb, busy;
  logic [1:0] req2 = '0, ack2;
  logic [31:0] addr2 = '0;
  logic [15:0] j2;
  logic [0:0] js2, jch2;
  logic jstb2, busy2;
`ifdef PRGMUX_PARITY_EN
  logic jerr = 1'b0, jpar, perr, jpar2, perr2;
`endif
  int checks = 0, failures = 0, ptr_m = 0;
  rec_t q[$];
  int order[$];
  int rr_exp[4] = '{0, 1, 2, 0};
  always #5 clk = ~clk;
  for (genvar g = 0; g < CH; g++) begin : g_addr
    assign addr[g*AW +: AW] = ad[g];
  end
  prgmux_seq #(.CH(CH), .AW(AW), .JW(JW), .SETUP(SETUP)) dut (
    .clk(clk), .resetn(resetn), .req(req), .addr(addr), .ack(ack),
    .j(j), .js(js), .jch(jch), .jstb(jstb), .busy(busy)
`ifdef PRGMUX_PARITY_EN
    , .jpar(jpar), .jerr(jerr), .perr(perr)
`endif
  );
  prgmux_seq #(.CH(2), .AW(16), .JW(16), .SETUP(0)) dut2 (
    .clk(clk), .resetn(resetn), .req(req2), .addr(addr2), .ack(ack2),
    .j(j2), .js(js2), .jch(jch2), .jstb(jstb2), .busy(busy2)
`ifdef PRGMUX_PARITY_EN
    , .jpar(jpar2), .jerr(jerr), .perr(perr2)
`endif
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // expands one transfer into its expected per-cycle outputs, or one idle cycle
  task automatic plan();
    rec_t r;
    int g;
    logic [CH-1:0] sh;
    logic [SW-1:0] a, t;
    g = -1;
    for (int i = 0; i < CH; i++) begin
      sh = req >> ((ptr_m + i) % CH);
      if (g < 0 && sh[0]) g = (ptr_m + i) % CH;
    end
    r = '0;
    r.dv = 1'b1;
    if (g < 0) begin
      q.push_back(r);
      return;
    end
    a = SW'(ad[CW'(g)]);
    ptr_m = (g + 1) % CH;
    for (int k = 0; k < BEATS; k++)
      for (int s = 0; s <= SETUP; s++) begin
        t = a >> (k * JW);
        r = '0;
        r.j = t[JW-1:0];
        r.js = 1'(k);
        r.jch = CW'(g);
        r.stb = s == SETUP;
        r.busy = 1'b1;
        r.dv = 1'b1;
        q.push_back(r);
      end
    r = '0;
    r.ack = CH'(1) << g;
    r.busy = 1'b1;
    q.push_back(r);
    r = '0;
    r.dv = 1'b1;
    q.push_back(r);
  endtask
  task automatic step();
    rec_t r;
    if (q.size() == 0) plan();
    tick();
    r = q.pop_front();
    check("busy", 64'(busy), 64'(r.busy));
    check("jstb", 64'(jstb), 64'(r.stb));
    check("ack", 64'(ack), 64'(r.ack));
    if (r.dv) begin
      check("j", 64'(j), 64'(r.j));
      check("js", 64'(js), 64'(r.js));
      check("jch", 64'(jch), 64'(r.jch));
`ifdef PRGMUX_PARITY_EN
      check("jpar", 64'(jpar), 64'(^r.j));
`endif
    end
    req &= ~r.ack;
  endtask
  task automatic drain();
    req = '0;
    while (q.size() != 0) step();
  endtask
  task automatic do_reset(input string tag);
    resetn = 1'b0;
    @(negedge clk);
    check({tag, "_j"}, 64'(j), 64'(0));
    check({tag, "_js"}, 64'(js), 64'(0));
    check({tag, "_jch"}, 64'(jch), 64'(0));
    check({tag, "_jstb"}, 64'(jstb), 64'(0));
    check({tag, "_ack"}, 64'(ack), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    q.delete();
    ptr_m = 0;
  endtask
  initial begin
    for (int c = 0; c < CH; c++) ad[CW'(c)] = '0;
    do_reset("rst");
    ad[0] = 19'h5ABCD;
    req = 3'b001;
    step();
    check("tp_c1_j", 64'(j), 64'(16'hABCD));
    check("tp_c1_js", 64'(js), 64'(0));
    step();
    check("tp_c2_jstb", 64'(jstb), 64'(1));
    step();
    check("tp_c3_j", 64'(j), 64'(16'h0005));
    check("tp_c3_js", 64'(js), 64'(1));
    step();
    step();
    check("tp_c5_ack", 64'(ack), 64'(3'b001));
    step();
    check("tp_c6_busy", 64'(busy), 64'(0));
    do_reset("rst2");
    req = 3'b111;
    for (int n = 0; n < 40 && order.size() < 4; n++) begin
      step();
      if (jstb && js == 1'b0) order.push_back(int'(jch));
      if (!busy) req = 3'b111;
    end
    check("rr_len", 64'(order.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      if (i < order.size()) check("rr_order", 64'(order[i]), 64'(rr_exp[i]));
    drain();
    ad[1] = 19'h12345;
    req = 3'b010;
    step();
    while (q.size() != 0) step();
    ad[0] = 19'h7FFFF;
    req = 3'b011;
    step();
    check("wrap_first", 64'(jch), 64'(0));
    while (q.size() != 0) step();
    step();
    check("wrap_second", 64'(jch), 64'(1));
    drain();
    ad[0] = AW'($urandom);
    req = 3'b001;
    repeat (4) step();
    resetn = 1'b0;
    #1;
    check("midrst_jstb", 64'(jstb), 64'(0));
    check("midrst_j", 64'(j), 64'(0));
    check("midrst_ack", 64'(ack), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    do_reset("midrst");
    step();
    check("restart_js", 64'(js), 64'(0));
    check("restart_jch", 64'(jch), 64'(0));
    drain();
    repeat (400) begin
      step();
      for (int c = 0; c < CH; c++)
        if (!req[CW'(c)] && $urandom_range(3) == 0) begin
          req[CW'(c)] = 1'b1;
          ad[CW'(c)] = AW'($urandom);
        end
      if ($urandom_range(5) == 0) ad[CW'($urandom_range(CH - 1))] = AW'($urandom);
      if ($urandom_range(15) == 0) req[CW'($urandom_range(CH - 1))] = 1'b0;
    end
    drain();
    addr2[15:0] = 16'hBEEF;
    req2 = 2'b01;
    tick();
    check("s0_jstb", 64'(jstb2), 64'(1));
    check("s0_j", 64'(j2), 64'(16'hBEEF));
    check("s0_js", 64'(js2), 64'(0));
    tick();
    check("s0_ack", 64'(ack2), 64'(2'b01));
    check("s0_jstb_done", 64'(jstb2), 64'(0));
    req2 = 2'b00;
    tick();
    check("s0_busy", 64'(busy2), 64'(0));
    check("s0_ack_once", 64'(ack2), 64'(0));
`ifdef PRGMUX_PARITY_EN
    ad[0] = 19'h00001;
    req = 3'b001;
    tick();
    check("par_j", 64'(j), 64'(16'h0001));
    check("par_jpar", 64'(jpar), 64'(1));
    tick();
    check("par_stb0", 64'(jstb), 64'(1));
    jerr = 1'b1;
    tick();
    jerr = 1'b0;
    check("par_replay_stb", 64'(jstb), 64'(0));
    check("par_replay_js", 64'(js), 64'(0));
    tick();
    check("par_stb0b", 64'(jstb), 64'(1));
    check("par_stb0b_js", 64'(js), 64'(0));
    tick();
    check("par_b1_js", 64'(js), 64'(1));
    tick();
    tick();
    check("par_ack", 64'(ack), 64'(3'b001));
    check("par_perr", 64'(perr), 64'(0));
    req = '0;
    tick();
    check("par_idle", 64'(busy), 64'(0));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
